// File: rtl/mem_pkg.sv
// Shared types and helpers for the mem_mod_clr RAM family.
package mem_pkg;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  localparam bit RDW_OLD = 1'b0;
  localparam bit RDW_NEW = 1'b1;

  function automatic int nbe(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/mem_mod_clr_if.sv
// Host-side bus of mem_mod_clr: control, write port and read port.
interface mem_mod_clr_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_ADDR   = 4
) ();

  localparam int ADDR_W = $clog2(MAX_ADDR);
  localparam int NBE    = mem_pkg::nbe(DATA_WIDTH);

  logic                  clr_req;
  logic                  busy;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [NBE-1:0]        wr_be;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_err;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_err;

  modport master (
    output clr_req, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    input  busy, wr_err, rd_data, rd_valid, rd_err
  );

  modport slave (
    input  clr_req, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    output busy, wr_err, rd_data, rd_valid, rd_err
  );

endinterface

// File: rtl/mem_rd_pipe.sv
// RD_LAT-deep delay line for read results; data only advances with a valid
// result so the output word holds its last value between reads.
module mem_rd_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_err,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic                  out_err,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  valid_q [RD_LAT];
  logic                  err_q   [RD_LAT];
  logic [DATA_WIDTH-1:0] data_q  [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        valid_q[i] <= 1'b0;
        err_q[i]   <= 1'b0;
        data_q[i]  <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      err_q[0]   <= in_valid & in_err;
      if (in_valid) data_q[0] <= in_data;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_err   = err_q[RD_LAT-1];
  assign out_data  = data_q[RD_LAT-1];

endmodule

// File: rtl/mem_mod_clr.sv
// Simple-dual-port RAM with byte-lane writes, pipelined reads, read-during-write
// bypass, out-of-range flags and a hardware clear sweep after reset or on request.
module mem_mod_clr
  import mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    MAX_ADDR   = 4,
  parameter int                    RD_LAT     = 1,
  parameter bit                    RDW_MODE   = RDW_OLD,
  parameter logic [DATA_WIDTH-1:0] CLR_VAL    = '0
) (
  input  logic          clk,
  input  logic          rst,
  mem_mod_clr_if.slave  bus
);

  localparam int                ADDR_W = $clog2(MAX_ADDR);
  localparam logic [ADDR_W:0]   WORDS  = (ADDR_W+1)'(MAX_ADDR);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(MAX_ADDR - 1);

  logic [DATA_WIDTH-1:0] mem [MAX_ADDR];

  state_t                state;
  logic [ADDR_W-1:0]     ptr;
  logic                  busy_q;
  logic                  wr_err_q;

  logic                  ready;
  logic                  wr_oob;
  logic                  rd_oob;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  same_addr;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Address checks are done one bit wider so no out-of-range address aliases.
  always_comb begin
    ready     = (state == ST_READY);
    wr_oob    = ({1'b0, bus.wr_addr} >= WORDS);
    rd_oob    = ({1'b0, bus.rd_addr} >= WORDS);
    wr_ok     = ready & bus.wr_en & ~wr_oob;
    rd_ok     = ready & bus.rd_en;
    same_addr = wr_ok & (bus.wr_addr == bus.rd_addr);

    lane_mask = '0;
    for (int b = 0; b < DATA_WIDTH; b++) lane_mask[b] = bus.wr_be[b/8];
    wr_merged = (mem[bus.wr_addr] & ~lane_mask) | (bus.wr_data & lane_mask);

    if (rd_oob)                             rd_word = '0;
    else if (RDW_MODE == RDW_NEW && same_addr) rd_word = wr_merged;
    else                                    rd_word = mem[bus.rd_addr];

    if (!ready) begin
      mem_we    = 1'b1;
      mem_waddr = ptr;
      mem_wdata = CLR_VAL;
    end else begin
      mem_we    = wr_ok;
      mem_waddr = bus.wr_addr;
      mem_wdata = wr_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Sweep walks ptr over every word once, then hands control back to the host.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_CLEAR;
      ptr      <= '0;
      busy_q   <= 1'b1;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= ready & bus.wr_en & wr_oob;
      case (state)
        ST_CLEAR: begin
          if (ptr == LAST) begin
            state  <= ST_READY;
            busy_q <= 1'b0;
            ptr    <= '0;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
        ST_READY: begin
          if (bus.clr_req) begin
            state  <= ST_CLEAR;
            busy_q <= 1'b1;
            ptr    <= '0;
          end
        end
        default: begin
          state  <= ST_CLEAR;
          busy_q <= 1'b1;
          ptr    <= '0;
        end
      endcase
    end
  end

  mem_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LAT     (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_ok),
    .in_err    (rd_oob),
    .in_data   (rd_word),
    .out_valid (bus.rd_valid),
    .out_err   (bus.rd_err),
    .out_data  (bus.rd_data)
  );

  assign bus.busy   = busy_q;
  assign bus.wr_err = wr_err_q;

endmodule

// File: tb/tb_mem_mod_clr.sv
// Drives an old-data and a new-data RAM instance with the same traffic and
// compares both against a word-array reference model every cycle.
module tb_mem_mod_clr;

  localparam int DW  = 16;
  localparam int MAX = 6;
  localparam int LAT = 2;
  localparam logic [DW-1:0] CLR = 16'h0000;

  typedef struct {
    int          due;
    logic [15:0] d_old;
    logic [15:0] d_new;
    logic        err;
  } rd_entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_req, wr_en, rd_en;
  logic [2:0]  wr_addr, rd_addr;
  logic [1:0]  wr_be;
  logic [15:0] wr_data;

  int tests = 0;
  int fails = 0;

  logic [15:0] model_mem [MAX];
  rd_entry_t   rd_q [$];
  int          sweep_left;
  int          cyc;
  logic [15:0] last_old, last_new;
  logic        exp_valid, exp_err, exp_wr_err, exp_busy;

  always #5 clk = ~clk;

  mem_mod_clr_if #(.DATA_WIDTH(DW), .MAX_ADDR(MAX)) if_old ();
  mem_mod_clr_if #(.DATA_WIDTH(DW), .MAX_ADDR(MAX)) if_new ();

  assign if_old.clr_req = clr_req;
  assign if_old.wr_en   = wr_en;
  assign if_old.wr_addr = wr_addr;
  assign if_old.wr_be   = wr_be;
  assign if_old.wr_data = wr_data;
  assign if_old.rd_en   = rd_en;
  assign if_old.rd_addr = rd_addr;
  assign if_new.clr_req = clr_req;
  assign if_new.wr_en   = wr_en;
  assign if_new.wr_addr = wr_addr;
  assign if_new.wr_be   = wr_be;
  assign if_new.wr_data = wr_data;
  assign if_new.rd_en   = rd_en;
  assign if_new.rd_addr = rd_addr;

  mem_mod_clr #(
    .DATA_WIDTH(DW), .MAX_ADDR(MAX), .RD_LAT(LAT), .RDW_MODE(1'b0), .CLR_VAL(CLR)
  ) dut_old (.clk(clk), .rst(rst), .bus(if_old));

  mem_mod_clr #(
    .DATA_WIDTH(DW), .MAX_ADDR(MAX), .RD_LAT(LAT), .RDW_MODE(1'b1), .CLR_VAL(CLR)
  ) dut_new (.clk(clk), .rst(rst), .bus(if_new));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old;
    for (int l = 0; l < 2; l++) if (be[l]) r[8*l +: 8] = d[8*l +: 8];
    return r;
  endfunction

  // Reference behaviour for one rising edge, computed from the inputs held in this cycle.
  task automatic model_edge();
    rd_entry_t e;
    cyc++;
    exp_wr_err = 1'b0;
    if (sweep_left > 0) begin
      model_mem[MAX - sweep_left] = CLR;
      sweep_left--;
    end else begin
      if (rd_en) begin
        e.due = cyc + LAT - 1;
        if (int'(rd_addr) >= MAX) begin
          e.d_old = 16'h0; e.d_new = 16'h0; e.err = 1'b1;
        end else begin
          e.d_old = model_mem[rd_addr];
          e.d_new = model_mem[rd_addr];
          if (wr_en && int'(wr_addr) < MAX && wr_addr == rd_addr)
            e.d_new = merge(model_mem[rd_addr], wr_data, wr_be);
          e.err = 1'b0;
        end
        rd_q.push_back(e);
      end
      if (wr_en) begin
        if (int'(wr_addr) < MAX) model_mem[wr_addr] = merge(model_mem[wr_addr], wr_data, wr_be);
        else exp_wr_err = 1'b1;
      end
      if (clr_req) sweep_left = MAX;
    end
    exp_busy = (sweep_left > 0);
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      e = rd_q.pop_front();
      exp_valid = 1'b1;
      exp_err   = e.err;
      last_old  = e.d_old;
      last_new  = e.d_new;
    end else begin
      exp_valid = 1'b0;
      exp_err   = 1'b0;
    end
  endtask

  task automatic check_output();
    chk("busy_old",     if_old.busy,     exp_busy);
    chk("busy_new",     if_new.busy,     exp_busy);
    chk("wr_err_old",   if_old.wr_err,   exp_wr_err);
    chk("wr_err_new",   if_new.wr_err,   exp_wr_err);
    chk("rd_valid_old", if_old.rd_valid, exp_valid);
    chk("rd_valid_new", if_new.rd_valid, exp_valid);
    chk("rd_err_old",   if_old.rd_err,   exp_err);
    chk("rd_err_new",   if_new.rd_err,   exp_err);
    chk("rd_data_old",  if_old.rd_data,  last_old);
    chk("rd_data_new",  if_new.rd_data,  last_new);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_output();
  endtask

  task automatic apply_stimulus(input bit we, input int wa, input logic [1:0] be,
                                input logic [15:0] wd, input bit re, input int ra,
                                input bit cr);
    wr_en = we; wr_addr = 3'(wa); wr_be = be; wr_data = wd;
    rd_en = re; rd_addr = 3'(ra); clr_req = cr;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 2'b00, 16'h0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    rd_q.delete();
    last_old = 16'h0; last_new = 16'h0;
    exp_valid = 1'b0; exp_err = 1'b0; exp_wr_err = 1'b0; exp_busy = 1'b1;
    sweep_left = MAX;
    check_output();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < MAX; a++) apply_stimulus(0, 0, 2'b00, 16'h0, 1, a, 0);
    idle(LAT);
  endtask

  initial begin
    rst = 1'b1;
    clr_req = 0; wr_en = 0; rd_en = 0;
    wr_addr = 0; rd_addr = 0; wr_be = 0; wr_data = 0;
    cyc = 0;
    for (int i = 0; i < MAX; i++) model_mem[i] = 'x;

    // Power-up sweep, then every word reads back as the clear value.
    do_reset();
    idle(MAX);
    read_all();

    // Byte-lane merge onto an existing word.
    apply_stimulus(1, 3, 2'b11, 16'hA55A, 0, 0, 0);
    apply_stimulus(1, 3, 2'b01, 16'h1234, 0, 0, 0);
    apply_stimulus(0, 0, 2'b00, 16'h0, 1, 3, 0);
    idle(1);
    chk("lane_merge_old", if_old.rd_data, 16'hA534);
    chk("lane_merge_new", if_new.rd_data, 16'hA534);

    // Fill every word, then stream all reads back to back.
    for (int a = 0; a < MAX; a++)
      apply_stimulus(1, a, 2'($urandom_range(0, 3)), 16'($urandom), 0, 0, 0);
    read_all();

    // Same-cycle read/write on one address in both bypass modes.
    apply_stimulus(1, 2, 2'b11, 16'h1111, 0, 0, 0);
    apply_stimulus(1, 2, 2'b11, 16'h2222, 1, 2, 0);
    idle(1);
    chk("rdw_old_mode", if_old.rd_data, 16'h1111);
    chk("rdw_new_mode", if_new.rd_data, 16'h2222);
    apply_stimulus(1, 2, 2'b10, 16'hABCD, 1, 2, 0);
    apply_stimulus(0, 0, 2'b00, 16'h0, 1, 2, 0);
    idle(LAT);

    // Out-of-range write and read, and an empty-lane write.
    apply_stimulus(1, 7, 2'b11, 16'hDEAD, 0, 0, 0);
    apply_stimulus(0, 0, 2'b00, 16'h0, 1, 6, 0);
    apply_stimulus(1, 1, 2'b00, 16'hFFFF, 1, 7, 0);
    idle(LAT);
    read_all();

    // Clear request with a read in the same cycle; reads during the sweep drop.
    apply_stimulus(0, 0, 2'b00, 16'h0, 1, 4, 1);
    for (int i = 0; i < MAX; i++) apply_stimulus(1, i, 2'b11, 16'h5A5A, 1, i, 0);
    read_all();

    // Reset part-way through a sweep restarts it from the first word.
    for (int a = 0; a < MAX; a++) apply_stimulus(1, a, 2'b11, 16'($urandom), 0, 0, 0);
    apply_stimulus(0, 0, 2'b00, 16'h0, 0, 0, 1);
    idle(2);
    do_reset();
    idle(MAX);
    read_all();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      int wa;
      int ra;
      wa = $urandom_range(0, 7);
      ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 7);
      apply_stimulus($urandom_range(0, 1), wa, 2'($urandom_range(0, 3)), 16'($urandom),
                     $urandom_range(0, 1), ra, ($urandom_range(0, 39) == 0));
    end
    idle(MAX + LAT);
    read_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
